canvas_arbiter: RTL and testbench

CANVAS_ARBITER -- requirements
Module: canvas_arbiter

---
 rtl/canvas_arbiter_if.sv | 29 ++
 rtl/canvas_arbiter.sv | 161 ++++++++++++++++
 tb/tb_canvas_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/canvas_arbiter_if.sv
// Client-side access bus of the canvas arbiter: two request/grant ports and a
// shared read-return path.
interface canvas_arbiter_if #(
   parameter int unsigned CBITS = 12
);
   logic             req0;
   logic             req1;
   logic             we0;
   logic             we1;
   logic [16:0]      addr0;
   logic [16:0]      addr1;
   logic [CBITS-1:0] wdata0;
   logic [CBITS-1:0] wdata1;
   logic             gnt0;
   logic             gnt1;
   logic             rvalid0;
   logic             rvalid1;
   logic [CBITS-1:0] rdata;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, rvalid0, rvalid1, rdata
   );
endinterface

// File: rtl/canvas_arbiter.sv
// Shares one single-port canvas RAM between two round-robin clients and a
// low-priority flush scanner that streams the canvas to the VGA adapter.
module canvas_arbiter #(
   parameter int unsigned WIDTH  = 320,
   parameter int unsigned HEIGHT = 240,
   parameter int unsigned CBITS  = 12
) (
   input  logic               clock,
   input  logic               resetn,
   canvas_arbiter_if.slave    cli,
   input  logic               flush_start,
   output logic               flush_busy,
   output logic               flush_done,
   output logic [16:0]        mem_addr,
   output logic [CBITS-1:0]   mem_data,
   output logic               mem_wren,
   input  logic [CBITS-1:0]   mem_q,
   output logic [8:0]         vga_x,
   output logic [7:0]         vga_y,
   output logic [CBITS-1:0]   vga_color,
   output logic               vga_plot
);
   localparam int unsigned ABITS = 17;
   localparam int unsigned XBITS = 9;
   localparam int unsigned YBITS = 8;
   localparam int unsigned NPIX  = WIDTH * HEIGHT;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [XBITS-1:0] x_q, x_d;
   logic [YBITS-1:0] y_q, y_d;
   logic [ABITS-1:0] a_q, a_d;
   logic             last1_q;
   logic             rv0_q, rv1_q, oor_q;
   logic             plot_q;
   logic [XBITS-1:0] vx_q;
   logic [YBITS-1:0] vy_q;
   logic [CBITS-1:0] col_q;
   logic             scan_rd;
   logic             cli_oor;

   // Round-robin between clients; last1_q records who was served most recently.
   always_comb begin
      cli.gnt0 = 1'b0;
      cli.gnt1 = 1'b0;
      if (cli.req0 && cli.req1) begin
         cli.gnt0 = last1_q;
         cli.gnt1 = ~last1_q;
      end else begin
         cli.gnt0 = cli.req0;
         cli.gnt1 = cli.req1;
      end
   end

   assign scan_rd = (state_q == S_SCAN) && !cli.req0 && !cli.req1;

   // RAM port mux; out-of-canvas client accesses are granted but never write.
   always_comb begin
      mem_addr = '0;
      mem_data = '0;
      mem_wren = 1'b0;
      cli_oor  = 1'b0;
      if (cli.gnt0) begin
         cli_oor  = 32'(cli.addr0) >= NPIX;
         mem_addr = cli.addr0;
         mem_data = cli.wdata0;
         mem_wren = cli.we0 && !cli_oor;
      end else if (cli.gnt1) begin
         cli_oor  = 32'(cli.addr1) >= NPIX;
         mem_addr = cli.addr1;
         mem_data = cli.wdata1;
         mem_wren = cli.we1 && !cli_oor;
      end else if (scan_rd) begin
         mem_addr = a_q;
      end
   end

   // Flush scanner next-state: raster walk that only advances on issued reads.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      a_d     = a_q;
      case (state_q)
         S_IDLE: begin
            if (flush_start) begin
               state_d = S_SCAN;
               x_d     = '0;
               y_d     = '0;
               a_d     = '0;
            end
         end
         S_SCAN: begin
            if (scan_rd) begin
               a_d = a_q + 17'd1;
               if (x_q == XBITS'(WIDTH - 1)) begin
                  x_d = '0;
                  if (y_q == YBITS'(HEIGHT - 1)) begin
                     state_d = S_DRAIN;
                     y_d     = '0;
                     a_d     = '0;
                  end else begin
                     y_d = y_q + 8'd1;
                  end
               end else begin
                  x_d = x_q + 9'd1;
               end
            end
         end
         S_DRAIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         a_q     <= '0;
         last1_q <= 1'b1;
         rv0_q   <= 1'b0;
         rv1_q   <= 1'b0;
         oor_q   <= 1'b0;
         plot_q  <= 1'b0;
         vx_q    <= '0;
         vy_q    <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         a_q     <= a_d;
         if (cli.gnt0)      last1_q <= 1'b0;
         else if (cli.gnt1) last1_q <= 1'b1;
         rv0_q   <= cli.gnt0 && !cli.we0;
         rv1_q   <= cli.gnt1 && !cli.we1;
         oor_q   <= cli_oor;
         plot_q  <= scan_rd;
         if (scan_rd) begin
            vx_q <= x_q;
            vy_q <= y_q;
         end
         if (plot_q) col_q <= mem_q;
      end
   end

   assign cli.rvalid0 = rv0_q;
   assign cli.rvalid1 = rv1_q;
   assign cli.rdata   = ((rv0_q || rv1_q) && !oor_q) ? mem_q : '0;
   assign flush_busy  = (state_q != S_IDLE);
   assign flush_done  = (state_q == S_DRAIN);
   assign vga_plot    = plot_q;
   assign vga_x       = vx_q;
   assign vga_y       = vy_q;
   // RAM data lands the cycle after the read; hold the last colour otherwise.
   assign vga_color   = plot_q ? mem_q : col_q;
endmodule

// File: tb/tb_canvas_arbiter.sv
// Directed bench: client vectors on a full-size canvas, flush sequences on a
// small canvas so whole scans stay short.
module tb_canvas_arbiter;
   localparam int unsigned SW = 12;
   localparam int unsigned SH = 5;
   localparam int unsigned SN = SW * SH;

   logic clock = 1'b0;
   logic resetn;
   logic ram_init;
   always #5 clock = ~clock;

   canvas_arbiter_if #(.CBITS(12)) bif ();
   canvas_arbiter_if #(.CBITS(12)) sif ();

   logic        b_fs, b_busy, b_done, b_wren, b_plot;
   logic [16:0] b_addr;
   logic [11:0] b_data, b_q, b_col;
   logic [8:0]  b_vx;
   logic [7:0]  b_vy;
   logic        s_fs, s_busy, s_done, s_wren, s_plot;
   logic [16:0] s_addr;
   logic [11:0] s_data, s_q, s_col;
   logic [8:0]  s_vx;
   logic [7:0]  s_vy;

   canvas_arbiter u_big (
      .clock(clock), .resetn(resetn), .cli(bif),
      .flush_start(b_fs), .flush_busy(b_busy), .flush_done(b_done),
      .mem_addr(b_addr), .mem_data(b_data), .mem_wren(b_wren), .mem_q(b_q),
      .vga_x(b_vx), .vga_y(b_vy), .vga_color(b_col), .vga_plot(b_plot));

   canvas_arbiter #(.WIDTH(SW), .HEIGHT(SH), .CBITS(12)) u_small (
      .clock(clock), .resetn(resetn), .cli(sif),
      .flush_start(s_fs), .flush_busy(s_busy), .flush_done(s_done),
      .mem_addr(s_addr), .mem_data(s_data), .mem_wren(s_wren), .mem_q(s_q),
      .vga_x(s_vx), .vga_y(s_vy), .vga_color(s_col), .vga_plot(s_plot));

   // Canvas RAM models: single port, registered read.
   logic [11:0] ram_b [0:131071];
   logic [11:0] ram_s [0:131071];
   always @(posedge clock) begin
      if (ram_init) begin
         for (int i = 0; i < 131072; i++) ram_b[i] <= 12'(i);
      end else if (b_wren) begin
         ram_b[b_addr] <= b_data;
      end
      b_q <= ram_b[b_addr];
   end
   always @(posedge clock) begin
      if (ram_init) begin
         for (int i = 0; i < 131072; i++) ram_s[i] <= 12'(i * 3 + 1);
      end else if (s_wren) begin
         ram_s[s_addr] <= s_data;
      end
      s_q <= ram_s[s_addr];
   end

   function automatic logic [11:0] s_col_of(input int p);
      return 12'(p * 3 + 1);
   endfunction

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic r0; logic w0; logic [16:0] a0; logic [11:0] d0;
      logic r1; logic w1; logic [16:0] a1; logic [11:0] d1;
      logic g0; logic g1; logic wren; logic [16:0] maddr; logic [11:0] mdata;
      logic rv0; logic rv1; logic [11:0] rdat;
   } vec_t;

   vec_t vt [13];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_clients();
      bif.req0 = 0; bif.req1 = 0; bif.we0 = 0; bif.we1 = 0;
      bif.addr0 = '0; bif.addr1 = '0; bif.wdata0 = '0; bif.wdata1 = '0;
      sif.req0 = 0; sif.req1 = 0; sif.we0 = 0; sif.we1 = 0;
      sif.addr0 = '0; sif.addr1 = '0; sif.wdata0 = '0; sif.wdata1 = '0;
   endtask

   // One flush on the small canvas; optional client read every other cycle.
   task automatic run_flush(input bit stall);
      int  p;
      int  busy_n;
      bit  seen_done;
      int  exp_done_cyc;
      p = 0; busy_n = 0; seen_done = 0;
      exp_done_cyc = stall ? int'(2 * SN + 1) : int'(SN + 1);
      s_fs = 1;
      @(negedge clock);
      check("busy_before_start", 32'(s_busy), 0);
      tick();
      s_fs = 0;
      for (int cyc = 1; cyc < 400 && !seen_done; cyc++) begin
         sif.req0  = stall && (cyc % 2 == 1);
         sif.addr0 = 17'(cyc);
         @(negedge clock);
         if (s_busy) busy_n++;
         if (s_plot) begin
            check("plot_x", 32'(s_vx), p % SW);
            check("plot_y", 32'(s_vy), p / SW);
            check("plot_color", 32'(s_col), 32'(s_col_of(p)));
            p++;
         end
         if (s_done) begin
            seen_done = 1;
            check("done_cycle", cyc, exp_done_cyc);
            check("done_with_plot", 32'(s_plot), 1);
            check("done_plot_count", p, SN);
         end
         tick();
      end
      sif.req0 = 0;
      check("flush_finished", 32'(seen_done), 1);
      check("busy_cycles", busy_n, exp_done_cyc);
      @(negedge clock);
      check("busy_after_done", 32'(s_busy), 0);
      check("hold_x", 32'(s_vx), SW - 1);
      check("hold_y", 32'(s_vy), SH - 1);
      check("hold_color", 32'(s_col), 32'(s_col_of(SN - 1)));
      for (int k = 0; k < 3; k++) begin
         tick();
         @(negedge clock);
         check("no_extra_done", 32'(s_done), 0);
         check("no_extra_plot", 32'(s_plot), 0);
      end
      tick();
   endtask

   initial begin
      //          r0 w0 a0     d0       r1 w1 a1     d1       g0 g1 wr maddr  mdata    rv0 rv1 rdat
      vt[0]  = '{0, 0, 0,     0,       0, 0, 0,     0,       0, 0, 0, 0,     0,       0,  0,  0};
      vt[1]  = '{1, 0, 5,     0,       0, 0, 0,     0,       1, 0, 0, 5,     0,       0,  0,  0};
      vt[2]  = '{0, 0, 0,     0,       0, 0, 0,     0,       0, 0, 0, 0,     0,       1,  0,  12'h005};
      vt[3]  = '{0, 0, 0,     0,       1, 1, 76799, 12'hF00, 0, 1, 1, 76799, 12'hF00, 0,  0,  0};
      vt[4]  = '{0, 0, 0,     0,       1, 0, 76799, 0,       0, 1, 0, 76799, 0,       0,  0,  0};
      vt[5]  = '{0, 0, 0,     0,       1, 1, 76800, 12'h123, 0, 1, 0, 76800, 0,       0,  1,  12'hF00};
      vt[6]  = '{0, 0, 0,     0,       1, 0, 76800, 0,       0, 1, 0, 76800, 0,       0,  0,  0};
      vt[7]  = '{1, 0, 10,    0,       1, 0, 20,    0,       1, 0, 0, 10,    0,       0,  1,  12'h000};
      vt[8]  = '{1, 0, 10,    0,       1, 0, 20,    0,       0, 1, 0, 20,    0,       1,  0,  12'h00A};
      vt[9]  = '{1, 1, 30,    12'h0AB, 1, 0, 40,    0,       1, 0, 1, 30,    12'h0AB, 0,  1,  12'h014};
      vt[10] = '{1, 0, 30,    0,       1, 0, 40,    0,       0, 1, 0, 40,    0,       0,  0,  0};
      vt[11] = '{1, 0, 30,    0,       0, 0, 0,     0,       1, 0, 0, 30,    0,       0,  1,  12'h028};
      vt[12] = '{0, 0, 0,     0,       0, 0, 0,     0,       0, 0, 0, 0,     0,       1,  0,  12'h0AB};

      idle_clients();
      b_fs = 0; s_fs = 0;
      resetn = 0; ram_init = 1;
      tick(); tick();
      ram_init = 0;
      @(negedge clock);
      check("rst_gnt0", 32'(bif.gnt0), 0);
      check("rst_gnt1", 32'(bif.gnt1), 0);
      check("rst_rvalid0", 32'(bif.rvalid0), 0);
      check("rst_rvalid1", 32'(bif.rvalid1), 0);
      check("rst_rdata", 32'(bif.rdata), 0);
      check("rst_wren", 32'(b_wren), 0);
      check("rst_busy", 32'(b_busy), 0);
      check("rst_done", 32'(b_done), 0);
      check("rst_plot", 32'(b_plot), 0);
      check("rst_vga_x", 32'(b_vx), 0);
      check("rst_vga_y", 32'(b_vy), 0);
      check("rst_vga_color", 32'(b_col), 0);
      check("rst_small_busy", 32'(s_busy), 0);
      tick();
      resetn = 1;

      // Client vectors, one per cycle.
      for (int i = 0; i < 13; i++) begin
         bif.req0 = vt[i].r0; bif.we0 = vt[i].w0; bif.addr0 = vt[i].a0; bif.wdata0 = vt[i].d0;
         bif.req1 = vt[i].r1; bif.we1 = vt[i].w1; bif.addr1 = vt[i].a1; bif.wdata1 = vt[i].d1;
         @(negedge clock);
         check($sformatf("v%0d_gnt0", i), 32'(bif.gnt0), 32'(vt[i].g0));
         check($sformatf("v%0d_gnt1", i), 32'(bif.gnt1), 32'(vt[i].g1));
         check($sformatf("v%0d_wren", i), 32'(b_wren), 32'(vt[i].wren));
         if (vt[i].g0 || vt[i].g1)
            check($sformatf("v%0d_mem_addr", i), 32'(b_addr), 32'(vt[i].maddr));
         if (vt[i].wren)
            check($sformatf("v%0d_mem_data", i), 32'(b_data), 32'(vt[i].mdata));
         check($sformatf("v%0d_rvalid0", i), 32'(bif.rvalid0), 32'(vt[i].rv0));
         check($sformatf("v%0d_rvalid1", i), 32'(bif.rvalid1), 32'(vt[i].rv1));
         if (vt[i].rv0 || vt[i].rv1)
            check($sformatf("v%0d_rdata", i), 32'(bif.rdata), 32'(vt[i].rdat));
         tick();
      end
      idle_clients();

      // Both clients held after reset alternate starting with client 0.
      resetn = 0;
      tick();
      resetn = 1;
      bif.req0 = 1; bif.addr0 = 17'd1;
      bif.req1 = 1; bif.addr1 = 17'd2;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         check($sformatf("rr%0d_gnt0", k), 32'(bif.gnt0), 32'(k % 2 == 0));
         check($sformatf("rr%0d_gnt1", k), 32'(bif.gnt1), 32'(k % 2 == 1));
         tick();
      end
      idle_clients();
      tick();

      run_flush(0);
      run_flush(1);

      // Reset in the middle of a flush, then a clean restart.
      s_fs = 1;
      tick();
      s_fs = 0;
      repeat (20) tick();
      resetn = 0;
      tick();
      resetn = 1;
      @(negedge clock);
      check("abort_busy", 32'(s_busy), 0);
      check("abort_plot", 32'(s_plot), 0);
      check("abort_done", 32'(s_done), 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         @(negedge clock);
         check("abort_quiet_plot", 32'(s_plot), 0);
         check("abort_quiet_done", 32'(s_done), 0);
      end
      tick();
      run_flush(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
